// File: rtl/sc_mux_adder_n_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : sc_mux_adder_n_pkg                                            |
// | Brief   : Shared FSM encodings, LFSR constants and clog2 helper for the |
// |           scaled stochastic mux adder.                                  |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
package sc_mux_adder_n_pkg;

  // Stream controller states
  typedef enum logic [1:0] {
    SC_ST_IDLE = 2'd0,
    SC_ST_RUN  = 2'd1,
    SC_ST_DONE = 2'd2
  } sc_state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam int          SC_LFSR_W        = 16;
  localparam logic [15:0] SC_LFSR_TAP_MASK = 16'hB400;

  // Ceiling log2, used to size the select index
  function automatic int sc_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_sel_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : sc_sel_gen                                                    |
// | Brief   : Select index generator for the stochastic mux adder.          |
// |           Round-robin counter by default; low bits of a 16-bit          |
// |           Fibonacci LFSR when SC_ADDER_LFSR_SEL_EN is defined.          |
// | Macro   : SC_ADDER_LFSR_SEL_EN                                          |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module sc_sel_gen
  import sc_mux_adder_n_pkg::*;
#(
  parameter int          SEL_W     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [SEL_W-1:0] sel
);

  // An all-zero seed would lock the LFSR; refuse it at elaboration
  if (LFSR_SEED == 16'h0000) begin : g_seed_chk
    $error("sc_sel_gen: LFSR_SEED must be nonzero");
  end

`ifdef SC_ADDER_LFSR_SEL_EN
  logic [SC_LFSR_W-1:0] lfsr;

  // LFSR: reseed on reset/clear, shift in the tap parity once per accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (clear) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[SC_LFSR_W-2:0], ^(lfsr & SC_LFSR_TAP_MASK)};
    end
  end

  assign sel = lfsr[SEL_W-1:0];
`else
  logic [SEL_W-1:0] rr_cnt;

  // Round-robin counter: wraps naturally at N because N is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_cnt <= '0;
    end else if (clear) begin
      rr_cnt <= '0;
    end else if (step) begin
      rr_cnt <= rr_cnt + 1'b1;
    end
  end

  assign sel = rr_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/sc_mux_adder_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : sc_mux_adder_n                                                |
// | Brief   : N-input scaled stochastic adder. Picks one input bit per      |
// |           accepted cycle with an N:1 mux and counts output ones over a  |
// |           2**STREAM_LEN_W bit stream.                                   |
// | Macro   : SC_ADDER_LFSR_SEL_EN (LFSR select instead of round-robin)     |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module sc_mux_adder_n
  import sc_mux_adder_n_pkg::*;
#(
  parameter int          NUM_INPUTS   = 4,
  parameter int          STREAM_LEN_W = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [NUM_INPUTS-1:0]   in_bits,
  output logic                    in_ready,
  output logic                    out_bit,
  output logic                    out_valid,
  output logic [STREAM_LEN_W:0]   ones_count,
  output logic                    done
);

  localparam int SEL_W = sc_clog2(NUM_INPUTS);

  if ((NUM_INPUTS < 2) || ((1 << SEL_W) != NUM_INPUTS)) begin : g_inputs_chk
    $error("sc_mux_adder_n: NUM_INPUTS must be a power of 2 and >= 2");
  end

  sc_state_e               state;
  sc_state_e               state_nxt;
  logic                    accept;
  logic                    clear;
  logic                    last;
  logic [STREAM_LEN_W-1:0] bit_cnt;
  logic [SEL_W-1:0]        sel;
  logic                    sel_bit;

  assign sel_bit = in_bits[sel];

  sc_sel_gen #(
    .SEL_W     (SEL_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_sel_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .step  (accept),
    .sel   (sel)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SC_ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; start/in_valid only matter in their own state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    clear     = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      SC_ST_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = SC_ST_RUN;
        end
      end
      SC_ST_RUN: begin
        in_ready = 1'b1;
        accept   = in_valid;
        last     = in_valid && (bit_cnt == {STREAM_LEN_W{1'b1}});
        if (last) begin
          state_nxt = SC_ST_DONE;
        end
      end
      SC_ST_DONE: begin
        state_nxt = SC_ST_IDLE;
      end
      default: begin
        state_nxt = SC_ST_IDLE;
      end
    endcase
  end

  // Output datapath: mux the selected bit, accumulate ones, advance the bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      ones_count <= '0;
      done       <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      out_valid <= accept;
      done      <= last;
      if (clear) begin
        ones_count <= '0;
        bit_cnt    <= '0;
      end else if (accept) begin
        out_bit    <= sel_bit;
        ones_count <= ones_count + {{STREAM_LEN_W{1'b0}}, sel_bit};
        bit_cnt    <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
